// File: rtl/branch_issue_ctrl.sv
// branch_issue_ctrl
// Sequencing controller for the branch/jump execute unit. It holds one
// control-transfer instruction (BRANCH/JAL/JALR) taken from decode. While it
// waits, it presents the held fields plus live operands to the execute unit.
// A taken transfer then raises a one-cycle redirect/flush. JAL/JALR with
// rd != 0 then write pc+4 back through a valid/ready port.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once the controller raises wb_valid, it keeps wb_valid, wb_rd
// and wb_data stable until it samples wb_ready high. The decode side
// transfers when dec_valid is high and the controller is in IDLE
// (dec_ready=1) without ext_kill.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   dec_valid/dec_ready/dec_*       decode hand-off (instr, pc, imm)
//   rs1_addr, rs2_addr              register-file read addresses
//   rs1_rdata, rs2_rdata            register-file read data
//   sb_rs1_busy, sb_rs2_busy        scoreboard pending-writer flags
//   ex_*                            execute unit drive and response
//   redirect_valid/addr, flush      fetch redirect pulse
//   fetch_stall                     hold fetch/decode while busy
//   wb_valid/rd/data/ready          link writeback port
//   ext_kill                        trap kill of held instruction
//   cnt_clr, stall_cnt              operand-wait statistics counter
//   dbg_state                       current FSM state for observation
module branch_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [31:0]      dec_instr,
    input  logic [31:0]      dec_pc,
    input  logic [31:0]      dec_imm,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [31:0]      rs1_rdata,
    input  logic [31:0]      rs2_rdata,
    input  logic             sb_rs1_busy,
    input  logic             sb_rs2_busy,
    output logic [31:0]      ex_instr,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs1_data,
    output logic [31:0]      ex_rs2_data,
    output logic [1:0]       ex_data1_depend,
    output logic [1:0]       ex_data2_depend,
    input  logic             ex_j_accept,
    input  logic             ex_j_wait,
    input  logic [31:0]      ex_j_addr,
    output logic             redirect_valid,
    output logic [31:0]      redirect_addr,
    output logic             flush,
    output logic             fetch_stall,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    input  logic             wb_ready,
    input  logic             ext_kill,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_REDIR = 2'd2,
        S_WBL   = 2'd3
    } state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t      state, state_nxt;
    logic [31:0] instr_q, pc_q, imm_q, target_q;

    logic        accept;
    logic        dec_is_ctrl;
    logic        held_is_jalr;
    logic        held_is_link;
    logic        resolve;
    logic        wait_inc;

    assign accept       = (state == S_IDLE) && dec_valid && !ext_kill;
    assign dec_is_ctrl  = (dec_instr[6:0] == OP_BRANCH) ||
                          (dec_instr[6:0] == OP_JAL)    ||
                          (dec_instr[6:0] == OP_JALR);
    assign held_is_jalr = (instr_q[6:0] == OP_JALR);
    assign held_is_link = (instr_q[6:0] == OP_JAL) || held_is_jalr;
    // The execute unit has resolved the transfer this cycle.
    assign resolve      = (state == S_WAIT) && !ext_kill && !ex_j_wait;
    // A killed cycle is not counted as an operand-wait cycle.
    assign wait_inc     = (state == S_WAIT) && !ext_kill && ex_j_wait;

    // Next-state logic; ext_kill overrides every transition out of a busy state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && dec_is_ctrl) state_nxt = S_WAIT;
            S_WAIT:  if (resolve) state_nxt = ex_j_accept ? S_REDIR : S_IDLE;
            S_REDIR: state_nxt = (held_is_link && (instr_q[11:7] != 5'd0)) ? S_WBL : S_IDLE;
            S_WBL:   if (wb_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (ext_kill && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Held instruction fields. Non-control opcodes are latched too and then
    // dropped; the fields are don't-care in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            target_q <= '0;
        end else begin
            if (accept) begin
                instr_q <= dec_instr;
                pc_q    <= dec_pc;
                imm_q   <= dec_imm;
            end
            if (resolve) begin
                // JALR targets clear bit 0 as the ISA requires.
                target_q <= held_is_jalr ? {ex_j_addr[31:1], 1'b0} : ex_j_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (wait_inc && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign dec_ready       = (state == S_IDLE);
    assign fetch_stall     = (state != S_IDLE);
    assign redirect_valid  = (state == S_REDIR);
    assign flush           = (state == S_REDIR);
    assign wb_valid        = (state == S_WBL);
    assign redirect_addr   = target_q;
    assign wb_rd           = instr_q[11:7];
    assign wb_data         = pc_q + 32'd4;
    assign rs1_addr        = instr_q[19:15];
    assign rs2_addr        = instr_q[24:20];
    assign ex_instr        = instr_q;
    assign ex_pc           = pc_q;
    assign ex_imm          = imm_q;
    assign ex_rs1_data     = rs1_rdata;
    assign ex_rs2_data     = rs2_rdata;
    assign ex_data1_depend = {1'b0, sb_rs1_busy};
    assign ex_data2_depend = {1'b0, sb_rs2_busy};
    assign dbg_state       = state;

endmodule

// File: doc/branch_issue_ctrl.md
# branch_issue_ctrl

Sequencing controller for the branch/jump execute unit in the scoreboard RISC-V core. Accepts one control-transfer instruction (BRANCH, JAL, JALR) from decode and holds it. Drives the execute unit each cycle with live register-file operands and scoreboard busy flags until the unit stops reporting wait. Then issues a one-cycle fetch redirect/flush if taken, and writes the link value (pc+4) to the register file for JAL/JALR through a valid/ready writeback port.

## Interface
Parameters:
- CNT_W, 16, width of the operand-wait statistics counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode presents a control instruction
- dec_ready  out  1  controller can accept (high only in IDLE)
- dec_instr  in  32  instruction word
- dec_pc  in  32  instruction address
- dec_imm  in  32  sign-extended immediate
- rs1_addr, rs2_addr  out  5  register-file read addresses (instr[19:15], instr[24:20] of held instruction)
- rs1_rdata, rs2_rdata  in  32  register-file read data
- sb_rs1_busy, sb_rs2_busy  in  1  scoreboard: source has a pending writer
- ex_instr, ex_imm, ex_pc  out  32  held instruction fields to execute unit
- ex_rs1_data, ex_rs2_data  out  32  pass-through of rs1_rdata/rs2_rdata
- ex_data1_depend, ex_data2_depend  out  2  {1'b0, sb_rsN_busy}; 2'b00 = operand valid
- ex_j_accept  in  1  execute unit: transfer taken
- ex_j_wait  in  1  execute unit: operands not ready
- ex_j_addr  in  32  execute unit: target address
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_addr  out  32  redirect target
- flush  out  1  kill younger in-flight instructions (same cycle as redirect_valid)
- fetch_stall  out  1  hold fetch/decode
- wb_valid  out  1  link writeback request
- wb_rd  out  5  link destination (instr[11:7])
- wb_data  out  32  held pc + 4
- wb_ready  in  1  writeback port grant
- ext_kill  in  1  exception/trap kill of held instruction
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  saturating count of operand-wait cycles

## Operation
- States: IDLE, WAIT, REDIR, WBL.
- IDLE: dec_ready=1. On dec_valid, latch instr/pc/imm. Opcode 1100011/1101111/1100111 → WAIT. Any other opcode is accepted and dropped, staying IDLE.
- WAIT: ex_* driven from held regs and live operands each cycle.
  - ex_j_wait=1: stay, stall_cnt+1.
  - ex_j_wait=0: register ex_j_accept and the target.
    - Taken → REDIR.
    - Not-taken → IDLE.
- Target register = ex_j_addr with bit0 forced 0 for JALR; other opcodes use ex_j_addr unchanged.
- REDIR: redirect_valid=flush=1 for exactly one cycle. Next state: JAL/JALR with rd≠0 → WBL, else IDLE.
- WBL: wb_valid=1 with wb_rd and wb_data stable until wb_ready sampled high, then → IDLE.
- fetch_stall=1 in every state except IDLE.
- ext_kill=1 in WAIT/REDIR/WBL → IDLE next cycle. Kill suppresses any redirect/wb not yet presented that cycle and wins over all transitions. In IDLE, a concurrent dec_valid is not accepted.
- pc+4: 32-bit modulo add (0xFFFFFFFC → 0x00000000).
- stall_cnt saturates at all-ones. cnt_clr wins over a simultaneous increment.

## Timing
- Reset (async assert, sync-to-clk deassert use): state=IDLE; held regs, stall_cnt, redirect_valid, flush, wb_valid, fetch_stall all 0; dec_ready=1.
- Accept at edge N. Operands ready → WAIT evaluates in cycle N+1. Taken → redirect_valid high in N+2. wb_valid earliest N+3.
- Not-taken, ready operands: dec_ready high again in N+2 (2-cycle occupancy).
- Outputs are registered state decodes, except ex_rs*_data/ex_data*_depend, which are combinational from inputs.
- Reset asserted mid-operation: all outputs go to reset values immediately; no partial redirect or wb.

## Test plan
- BEQ x1,x2 with x1=x2=5, no busy, pc=0x100, imm=0x20 → redirect_valid+flush one cycle at N+2, redirect_addr=0x120, no wb, dec_ready at N+3.
- BNE with equal operands → no redirect, dec_ready at N+2, stall_cnt unchanged.
- JALR rd=x5, rs1=0x2001, imm=0, sb_rs1_busy high 3 cycles → stall_cnt=3, redirect_addr=0x2000, then wb_valid with wb_rd=5, wb_data=pc+4. Hold wb_ready low 2 cycles → wb stays stable.
- JAL rd=x0, pc=0xFFFFFFFC → redirect issued, no wb; a separate JAL rd=x1 at that pc gives wb_data=0x00000000.
- ext_kill in WAIT with operands busy → IDLE next cycle, no redirect/wb. rst_n pulse during WBL → wb_valid drops immediately.
- stall_cnt preloaded to all-ones with continued waits → stays all-ones. cnt_clr with a concurrent wait → 0.
